// File: rtl/iss_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iss_pkg : shared FU type codes, default sizes, raw/reorder mapping   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package iss_pkg;

   localparam int ISQ_DEPTH_DEF        = 64;
   localparam int ISQ_IDX_BITS_NUM_DEF = 6;

   typedef enum logic [1:0] {
      FU_ALU = 2'd0,
      FU_MUL = 2'd1,
      FU_MEM = 2'd2,
      FU_BRN = 2'd3
   } fu_typ_e;

   // The mapping is an involution, so it converts in both directions.
   function automatic int unsigned map_idx(input int unsigned idx, input logic arch,
                                           input int unsigned idx_bits);
      return idx ^ (32'(arch) << (idx_bits - 1));
   endfunction

endpackage
`default_nettype wire

// File: rtl/iss_sch_pri_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pri_enc : lowest-set-bit encoder with valid flag                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pri_enc #(
   parameter int N = 64,
   parameter int W = 6
) (
   input  logic [N-1:0] req,
   output logic         vld,
   output logic [W-1:0] idx
);

   always_comb begin
      vld = 1'b0;
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            vld = 1'b1;
            idx = W'(i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/iss_sch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iss_sch : picks up to 2 ALU, 1 MUL, 1 MEM ready lines per cycle      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module iss_sch
   import iss_pkg::*;
#(
   parameter int ISQ_DEPTH        = ISQ_DEPTH_DEF,
   parameter int ISQ_IDX_BITS_NUM = ISQ_IDX_BITS_NUM_DEF,
   parameter int MUL_LAT          = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [ISQ_DEPTH-1:0]        tpu_inst_rdy,
   input  logic [2*ISQ_DEPTH-1:0]      fu_typ_flat,
   input  logic                        arch,
   input  logic [ISQ_DEPTH-1:0]        lin_clr,
   input  logic                        flush,
   input  logic                        mem_rdy,
   output logic                        alu0_vld,
   output logic                        alu1_vld,
   output logic                        mul_vld,
   output logic                        mem_vld,
   output logic [ISQ_IDX_BITS_NUM-1:0] alu0_idx,
   output logic [ISQ_IDX_BITS_NUM-1:0] alu1_idx,
   output logic [ISQ_IDX_BITS_NUM-1:0] mul_idx,
   output logic [ISQ_IDX_BITS_NUM-1:0] mem_idx,
   output logic [ISQ_DEPTH-1:0]        iss_vec
);

   localparam int CNT_W = $clog2(MUL_LAT) + 1;
   localparam int IW    = ISQ_IDX_BITS_NUM;

   logic [ISQ_DEPTH-1:0] r_issued;
   logic [CNT_W-1:0]     r_mul_cnt;

   logic [ISQ_DEPTH-1:0] w_cand, w_alu0_req, w_alu_req, w_alu1_req, w_mul_req, w_mem_req;
   logic [ISQ_DEPTH-1:0] w_alu0_oh, w_gnt_raw;
   logic                 w_alu0_vld, w_alu1_vld, w_mul_vld, w_mem_vld;
   logic [IW-1:0]        w_alu0_reo, w_alu1_reo, w_mul_reo, w_mem_reo;
   logic [IW-1:0]        w_alu0_raw, w_alu1_raw, w_mul_raw, w_mem_raw;

   // Candidates and per-port request masks, all in reordered space.
   always_comb begin
      for (int i = 0; i < ISQ_DEPTH; i++) begin
         w_cand[i] = tpu_inst_rdy[i]
                   & ~r_issued[IW'(map_idx(i, arch, IW))]
                   & ~lin_clr[IW'(map_idx(i, arch, IW))]
                   & ~flush;
         w_alu_req[i]  = w_cand[i] & (fu_typ_flat[2*i +: 2] == FU_ALU);
         w_alu0_req[i] = w_alu_req[i] | (w_cand[i] & (fu_typ_flat[2*i +: 2] == FU_BRN));
         w_mul_req[i]  = w_cand[i] & (fu_typ_flat[2*i +: 2] == FU_MUL) & (r_mul_cnt == '0);
         w_mem_req[i]  = w_cand[i] & (fu_typ_flat[2*i +: 2] == FU_MEM) & mem_rdy;
      end
   end

   always_comb begin
      w_alu0_oh = '0;
      if (w_alu0_vld) w_alu0_oh[w_alu0_reo] = 1'b1;
   end
   assign w_alu1_req = w_alu_req & ~w_alu0_oh;

   pri_enc #(.N(ISQ_DEPTH), .W(IW)) u_enc_alu0 (.req(w_alu0_req), .vld(w_alu0_vld), .idx(w_alu0_reo));
   pri_enc #(.N(ISQ_DEPTH), .W(IW)) u_enc_alu1 (.req(w_alu1_req), .vld(w_alu1_vld), .idx(w_alu1_reo));
   pri_enc #(.N(ISQ_DEPTH), .W(IW)) u_enc_mul  (.req(w_mul_req),  .vld(w_mul_vld),  .idx(w_mul_reo));
   pri_enc #(.N(ISQ_DEPTH), .W(IW)) u_enc_mem  (.req(w_mem_req),  .vld(w_mem_vld),  .idx(w_mem_reo));

   assign w_alu0_raw = IW'(map_idx(32'(w_alu0_reo), arch, IW));
   assign w_alu1_raw = IW'(map_idx(32'(w_alu1_reo), arch, IW));
   assign w_mul_raw  = IW'(map_idx(32'(w_mul_reo),  arch, IW));
   assign w_mem_raw  = IW'(map_idx(32'(w_mem_reo),  arch, IW));

   always_comb begin
      w_gnt_raw = '0;
      if (w_alu0_vld) w_gnt_raw[w_alu0_raw] = 1'b1;
      if (w_alu1_vld) w_gnt_raw[w_alu1_raw] = 1'b1;
      if (w_mul_vld)  w_gnt_raw[w_mul_raw]  = 1'b1;
      if (w_mem_vld)  w_gnt_raw[w_mem_raw]  = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         alu0_vld  <= 1'b0;
         alu1_vld  <= 1'b0;
         mul_vld   <= 1'b0;
         mem_vld   <= 1'b0;
         alu0_idx  <= '0;
         alu1_idx  <= '0;
         mul_idx   <= '0;
         mem_idx   <= '0;
         iss_vec   <= '0;
         r_issued  <= '0;
         r_mul_cnt <= '0;
      end else begin
         alu0_vld <= w_alu0_vld;
         alu1_vld <= w_alu1_vld;
         mul_vld  <= w_mul_vld;
         mem_vld  <= w_mem_vld;
         alu0_idx <= w_alu0_vld ? w_alu0_raw : '0;
         alu1_idx <= w_alu1_vld ? w_alu1_raw : '0;
         mul_idx  <= w_mul_vld  ? w_mul_raw  : '0;
         mem_idx  <= w_mem_vld  ? w_mem_raw  : '0;
         iss_vec  <= w_gnt_raw;
         // Clear wins over set so a line deallocated this cycle is free again.
         r_issued <= flush ? '0 : ((r_issued | w_gnt_raw) & ~lin_clr);
         // Flush leaves the multiplier countdown alone: the unit is still busy.
         if (w_mul_vld)
            r_mul_cnt <= CNT_W'(MUL_LAT - 1);
         else if (r_mul_cnt != '0)
            r_mul_cnt <= r_mul_cnt - 1'b1;
      end
   end

endmodule
`default_nettype wire
